// File: rtl/ysyx_23060025_ifu_fq.sv
// ysyx_23060025_ifu_fq
// Instruction fetch unit with a small circular fetch queue in front of decode.
// Issues one icache request at a time (out_psel/out_paddr held until
// out_pready), pushes {pc, inst} on each accepted response and presents the
// queue head to decode. A redirect flushes the queue and loads a new PC; a
// response still in flight during a redirect is discarded.
//
// Ports:
//   clock, reset           - clock, asynchronous active-high reset
//   redirect_valid_i       - flush queue and load redirect_target_i (word aligned)
//   redirect_target_i      - new fetch PC
//   halt_i                 - stop issuing new requests; in-flight one completes
//   ds_allowin_i           - decode consumes the head entry this cycle
//   fs_to_ds_valid_o       - head entry valid (masked during redirect)
//   if_inst_o, if_pc_o     - head entry contents, zero when empty
//   fq_count_o             - queue occupancy
//   out_psel, out_paddr    - icache request and its registered address
//   out_pready, out_prdata - single-cycle icache response
module ysyx_23060025_ifu_fq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FQ_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET_VAL = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]         redirect_target_i,
  input  logic                          halt_i,
  input  logic                          ds_allowin_i,
  output logic                          fs_to_ds_valid_o,
  output logic [DATA_WIDTH-1:0]         if_inst_o,
  output logic [ADDR_WIDTH-1:0]         if_pc_o,
  output logic [$clog2(FQ_DEPTH):0]     fq_count_o,
  output logic                          out_psel,
  output logic [ADDR_WIDTH-1:0]         out_paddr,
  input  logic                          out_pready,
  input  logic [DATA_WIDTH-1:0]         out_prdata
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  logic [ADDR_WIDTH-1:0] pc_q   [FQ_DEPTH];
  logic [DATA_WIDTH-1:0] inst_q [FQ_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_post;
  logic                  push;
  logic                  pop;

  always_comb begin
    pc_plus4    = fetch_pc + ADDR_WIDTH'(4);
    redirect_pc = {redirect_target_i[ADDR_WIDTH-1:2], 2'b00};
    push        = (state == WAIT) & out_pready & ~redirect_valid_i;
    pop         = fs_to_ds_valid_o & ds_allowin_i;
    // occupancy after this edge's push/pop; decides back-to-back issue
    count_post  = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    out_psel         = (state == WAIT) || (state == DROP);
    fq_count_o       = count;
    fs_to_ds_valid_o = (count != '0) & ~redirect_valid_i;
    if_pc_o          = (count != '0) ? pc_q[head]   : '0;
    if_inst_o        = (count != '0) ? inst_q[head] : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= PC_RESET_VAL;
      out_paddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!halt_i && !redirect_valid_i && (count < FULL)) begin
            state     <= WAIT;
            out_paddr <= fetch_pc;
          end
        end
        WAIT: begin
          if (redirect_valid_i) begin
            // response arriving with the redirect is stale; otherwise wait it out
            state <= out_pready ? IDLE : DROP;
          end else if (out_pready) begin
            fetch_pc <= pc_plus4;
            if (!halt_i && (count_post < FULL)) begin
              out_paddr <= pc_plus4;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (out_pready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // redirect wins over the fetch_pc increment in any state
      if (redirect_valid_i) fetch_pc <= redirect_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count_post;
    end
  end

  // payload storage needs no reset: outputs are masked by count
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[tail]   <= fetch_pc;
      inst_q[tail] <= out_prdata;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_ifu_fq.sv
module tb_ysyx_23060025_ifu_fq;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        halt_i;
  logic        ds_allowin_i;
  logic        fs_to_ds_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic [2:0]  fq_count_o;
  logic        out_psel;
  logic [31:0] out_paddr;
  logic        out_pready;
  logic [31:0] out_prdata;

  ysyx_23060025_ifu_fq #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .FQ_DEPTH    (DEPTH),
    .PC_RESET_VAL(32'h8000_0000)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .redirect_valid_i (redirect_valid_i),
    .redirect_target_i(redirect_target_i),
    .halt_i           (halt_i),
    .ds_allowin_i     (ds_allowin_i),
    .fs_to_ds_valid_o (fs_to_ds_valid_o),
    .if_inst_o        (if_inst_o),
    .if_pc_o          (if_pc_o),
    .fq_count_o       (fq_count_o),
    .out_psel         (out_psel),
    .out_paddr        (out_paddr),
    .out_pready       (out_pready),
    .out_prdata       (out_prdata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus for the next cycle
  logic        g_redir, g_halt, g_allow, g_rdy;
  logic [31:0] g_tgt;

  // reference model: queue contents, next fetch PC, and request status
  logic [31:0] mq_pc [$];
  logic [31:0] mq_in [$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_in.delete();
    m_pc   = 32'h8000_0000;
    m_addr = 32'h0;
    m_busy = 0;
    m_drop = 0;
  endtask

  // Called at a negedge: apply inputs, check outputs, advance the model, run one clock.
  task automatic cyc();
    int          sz;
    bit          pop;
    logic [31:0] rdata;
    rdata             = $urandom;
    redirect_valid_i  = g_redir;
    redirect_target_i = g_tgt;
    halt_i            = g_halt;
    ds_allowin_i      = g_allow;
    out_pready        = g_rdy;
    out_prdata        = rdata;
    #1;
    sz = mq_pc.size();
    chk("psel",  64'(out_psel),         64'(m_busy));
    chk("paddr", 64'(out_paddr),        64'(m_addr));
    chk("count", 64'(fq_count_o),       64'(sz));
    chk("valid", 64'(fs_to_ds_valid_o), 64'((sz != 0) && !g_redir));
    chk("if_pc", 64'(if_pc_o),          64'((sz != 0) ? mq_pc[0] : 32'h0));
    chk("if_inst", 64'(if_inst_o),      64'((sz != 0) ? mq_in[0] : 32'h0));

    pop = (sz != 0) && !g_redir && g_allow;
    if (pop) begin
      mq_pc.delete(0);
      mq_in.delete(0);
    end
    if (m_busy) begin
      if (g_rdy) begin
        if (m_drop || g_redir) begin
          m_busy = 0;
        end else begin
          mq_pc.push_back(m_pc);
          mq_in.push_back(rdata);
          m_pc = m_pc + 32'd4;
          if (!g_halt && mq_pc.size() < DEPTH) m_addr = m_pc;
          else m_busy = 0;
        end
        m_drop = 0;
      end else if (g_redir) begin
        m_drop = 1;
      end
    end else if (!g_halt && !g_redir && sz < DEPTH) begin
      m_busy = 1;
      m_addr = m_pc;
    end
    if (g_redir) begin
      mq_pc.delete();
      mq_in.delete();
      m_pc = g_tgt & 32'hFFFF_FFFC;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    g_redir = 0; g_halt = 0; g_allow = 1; g_rdy = 0; g_tgt = 32'h0;
    redirect_valid_i = 0; redirect_target_i = 0; halt_i = 0;
    ds_allowin_i = 0; out_pready = 0; out_prdata = 0;
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    chk("rst_psel",  64'(out_psel),         64'(0));
    chk("rst_paddr", 64'(out_paddr),        64'(0));
    chk("rst_count", 64'(fq_count_o),       64'(0));
    chk("rst_valid", 64'(fs_to_ds_valid_o), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    // back-to-back fetch from the reset PC
    g_allow = 1;
    g_rdy = m_busy; cyc();
    chk("b2b_a0", 64'(out_paddr), 64'h8000_0000);
    g_rdy = m_busy; cyc();
    chk("b2b_a1", 64'(out_paddr), 64'h8000_0004);
    chk("b2b_pc0", 64'(if_pc_o), 64'h8000_0000);
    g_rdy = m_busy; cyc();
    chk("b2b_a2", 64'(out_paddr), 64'h8000_0008);
    chk("b2b_pc1", 64'(if_pc_o), 64'h8000_0004);

    // fill the queue with decode stalled
    g_allow = 0;
    repeat (8) begin g_rdy = m_busy; cyc(); end
    chk("full_count", 64'(fq_count_o), 64'(DEPTH));
    chk("full_psel",  64'(out_psel),   64'(0));
    g_allow = 1; g_rdy = 0; cyc();
    g_allow = 0; cyc();
    chk("refill_psel", 64'(out_psel), 64'(1));

    // redirect while waiting, response three cycles later
    g_redir = 1; g_tgt = 32'h8000_1002; g_rdy = 0; cyc();
    chk("drop_count", 64'(fq_count_o), 64'(0));
    g_redir = 0; cyc(); cyc();
    g_rdy = 1; cyc();
    chk("drop_done_count", 64'(fq_count_o), 64'(0));
    chk("drop_done_psel",  64'(out_psel),   64'(0));
    g_rdy = 0; cyc();
    chk("redir_addr", 64'(out_paddr), 64'h8000_1000);

    // redirect coinciding with the response
    g_redir = 1; g_tgt = 32'h8000_2000; g_rdy = 1; cyc();
    chk("same_count", 64'(fq_count_o), 64'(0));
    g_redir = 0; g_rdy = 0; cyc();
    chk("same_addr", 64'(out_paddr), 64'h8000_2000);

    // PC wrap
    g_allow = 1;
    g_redir = 1; g_tgt = 32'hFFFF_FFFC; g_rdy = 0; cyc();
    g_redir = 0; g_rdy = 1; cyc();
    g_rdy = 0; cyc();
    chk("wrap_a0", 64'(out_paddr), 64'hFFFF_FFFC);
    g_rdy = 1; cyc();
    chk("wrap_a1", 64'(out_paddr), 64'h0);

    // halt during WAIT: response still pushed, then no new requests
    g_halt = 1; g_rdy = 1; cyc();
    chk("halt_psel", 64'(out_psel), 64'(0));
    g_rdy = 0;
    repeat (3) begin cyc(); chk("halt_hold", 64'(out_psel), 64'(0)); end
    g_halt = 0; cyc();
    chk("unhalt_psel", 64'(out_psel), 64'(1));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      g_redir = ($urandom_range(0, 39) == 0);
      g_tgt   = $urandom;
      if ($urandom_range(0, 24) == 0) g_halt = ~g_halt;
      g_allow = ($urandom_range(0, 9) < 7);
      g_rdy   = m_busy && ($urandom_range(0, 2) != 0);
      cyc();
    end

    // reset in the middle of a request
    g_redir = 0; g_halt = 0; g_rdy = 0;
    for (int i = 0; i < 20 && !m_busy; i++) cyc();
    chk("pre_rst_busy", 64'(out_psel), 64'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_psel",  64'(out_psel),   64'(0));
    chk("mid_rst_paddr", 64'(out_paddr),  64'(0));
    chk("mid_rst_count", 64'(fq_count_o), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    g_allow = 1;
    repeat (10) begin g_rdy = m_busy; cyc(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_ifu_fq.md
YSYX_23060025_IFU_FQ -- requirements
Module: ysyx_23060025_ifu_fq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC/bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, >=2.
REQ-004 SHALL have parameter PC_RESET_VAL, default 32'h8000_0000, first fetch address.
REQ-005 SHALL use one clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-006 SHALL have the following ports, as name  direction  width  meaning:
- clock  in  1  clock.
- reset  in  1  async active-high reset.
- redirect_valid_i  in  1  flush plus new PC.
- redirect_target_i  in  ADDR_WIDTH  redirect PC.
- halt_i  in  1  stop issuing new fetches (ebreak).
- ds_allowin_i  in  1  decode accepts head entry.
- fs_to_ds_valid_o  out  1  queue head valid.
- if_inst_o  out  DATA_WIDTH  head instruction.
- if_pc_o  out  ADDR_WIDTH  head PC.
- fq_count_o  out  $clog2(FQ_DEPTH)+1  queue occupancy.
- out_psel  out  1  icache request, held until out_pready.
- out_paddr  out  ADDR_WIDTH  request address, registered.
- out_pready  in  1  one-cycle response strobe.
- out_prdata  in  DATA_WIDTH  response data, valid with out_pready.

Function
REQ-007 SHALL keep fetch_pc; redirect loads redirect_target_i with bits [1:0] forced to 0.
REQ-008 SHALL implement FSM IDLE, WAIT, DROP; out_psel=1 exactly in WAIT and DROP.
REQ-009 IDLE->WAIT SHALL occur when !halt_i, !redirect_valid_i, fq_count<FQ_DEPTH; out_paddr<=fetch_pc at that edge.
REQ-010 In WAIT with out_pready and no redirect: push {fetch_pc,out_prdata} to queue; fetch_pc+=4 (mod 2^ADDR_WIDTH, wraps).
REQ-011 Same edge as REQ-010: if !halt_i and post-update count<FQ_DEPTH, stay WAIT with out_paddr<=fetch_pc+4 (back-to-back); else ->IDLE.
REQ-012 Redirect in WAIT without out_pready: ->DROP; out_paddr unchanged until response.
REQ-013 In DROP, out_pready SHALL discard out_prdata and go ->IDLE; no push; a further redirect in DROP only updates fetch_pc.
REQ-014 Redirect with out_pready in the same cycle (WAIT): response discarded, ->IDLE, fetch_pc<=target.
REQ-015 Redirect in any state SHALL empty the queue that edge (count=0, pointers reset); redirect outranks push and pop.
REQ-016 At most one outstanding request; out_paddr SHALL NOT change while a request awaits out_pready.
REQ-017 fs_to_ds_valid_o = (fq_count!=0) & !redirect_valid_i; if_inst_o/if_pc_o SHALL show head entry combinationally (0 when empty).
REQ-018 Pop SHALL occur when fs_to_ds_valid_o & ds_allowin_i; simultaneous push and pop leaves count unchanged.
REQ-019 Queue SHALL be circular, pointers $clog2(FQ_DEPTH) bits wrapping modulo FQ_DEPTH; never overflow or underflow.
REQ-020 halt_i SHALL NOT cancel an outstanding request; the response is still pushed and the queue still drains.

Reset
REQ-021 On reset: state IDLE, fetch_pc=PC_RESET_VAL, out_paddr=0, out_psel=0, queue empty, fq_count_o=0, fs_to_ds_valid_o=0.
REQ-022 Reset mid-request SHALL drop the outstanding transaction; icache is reset by the same reset.

Verification
REQ-023 Release reset, out_pready one cycle after each psel, ds_allowin_i=1 -> out_paddr 0x80000000, 0x80000004, 0x80000008 back-to-back; if_pc_o follows in order.
REQ-024 ds_allowin_i=0, FQ_DEPTH=4 -> exactly 4 pushes, fq_count_o=4, out_psel=0; one pop -> next request issued next cycle.
REQ-025 Redirect to 0x80001002 while WAIT, response 3 cycles later -> response discarded, queue empty, next out_paddr=0x80001000.
REQ-026 Redirect and out_pready same cycle -> no push, count=0, next request at target.
REQ-027 fetch_pc=0xFFFFFFFC, response -> next out_paddr=0x00000000.
REQ-028 halt_i=1 during WAIT -> response pushed, FSM IDLE, no further out_psel until halt_i=0.
